// File: rtl/cla_seq_adder_ctrl.sv
// Wide adder sequencer: streams nibble pairs LSB-first through an external 4-bit
// adder that has no carry-in; a propagated carry costs one extra +1 "fix" pass.
//   state | meaning
//   IDLE  | waiting for start, adder inputs parked at 0
//   ADD   | nibble idx of A and B on the adder
//   FIX   | partial sum tmp + 1 to absorb the incoming carry
//   DONE  | result complete, one-cycle done pulse
module cla_seq_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES:0]   result,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [4:0]           add_out
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          c1;
  logic [3:0]    tmp;
  logic          last;

  assign last = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    add_a    = 4'd0;
    add_b    = 4'd0;
    case (state)
      IDLE: if (start) state_nx = ADD;
      ADD: begin
        busy  = 1'b1;
        add_a = a_q[4*idx +: 4];
        add_b = b_q[4*idx +: 4];
        if (carry)     state_nx = FIX;
        else if (last) state_nx = DONE;
      end
      FIX: begin
        busy     = 1'b1;
        add_a    = tmp;
        add_b    = 4'b0001;
        state_nx = last ? DONE : ADD;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The top carry bit lands in result[W] on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      c1     <= 1'b0;
      tmp    <= 4'd0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          idx   <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          if (!carry) begin
            result[4*idx +: 4] <= add_out[3:0];
            carry              <= add_out[4];
            idx                <= idx + IW'(1);
            if (last) result[W] <= add_out[4];
          end else begin
            tmp <= add_out[3:0];
            c1  <= add_out[4];
          end
        end
        FIX: begin
          result[4*idx +: 4] <= add_out[3:0];
          carry              <= c1 | add_out[4];
          idx                <= idx + IW'(1);
          if (last) result[W] <= c1 | add_out[4];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: 4-nibble and 1-nibble builds share one stimulus
// stream; each has its own cycle model and result/latency scoreboard.
module tb_cla_seq_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  int          total = 0;
  int          passed = 0;
  longint      cyc = 0;

  typedef struct {
    logic [16:0] sum;
    int          lat;
    longint      first;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Exact sum plus latency: one fix pass for every nibble whose incoming carry is 1.
  function automatic void model(input int n, input logic [15:0] a, input logic [15:0] b,
                                output logic [16:0] sum, output int lat);
    logic [31:0] m;
    int          f;
    f = 0;
    for (int i = 1; i < n; i++) begin
      m = (32'd1 << (4 * i)) - 32'd1;
      if ((((32'(a) & m) + (32'(b) & m)) >> (4 * i)) != 32'd0) f++;
    end
    m   = (32'd1 << (4 * n)) - 32'd1;
    sum = 17'((32'(a) & m) + (32'(b) & m));
    lat = n + f + 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int N = (g == 0) ? 4 : 1;
    localparam int W = 4 * N;

    logic       busy, done;
    logic [W:0] result;
    logic [3:0] add_a, add_b;
    logic [4:0] add_out;
    exp_t       q[$];
    exp_t       ent;
    exp_t       got;
    logic [16:0] s;
    int         l;
    int         rem = 0;
    int         accepts = 0;

    assign add_out = {1'b0, add_a} + {1'b0, add_b};

    cla_seq_adder_ctrl #(.NIBBLES(N)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op_a    (op_a[W-1:0]),
      .op_b    (op_b[W-1:0]),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_out (add_out)
    );

    // rem counts down from the latency: >=2 busy, 1 done, 0 idle and ready.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem <= 0;
        q.delete();
      end else if (rem == 0) begin
        if (start) begin
          model(N, op_a, op_b, s, l);
          ent.sum   = s;
          ent.lat   = l;
          ent.first = cyc + 1;
          q.push_back(ent);
          rem     <= l;
          accepts <= accepts + 1;
        end
      end else begin
        rem <= rem - 1;
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        check($sformatf("n%0d_busy", N), 64'(busy), 64'(rem >= 2));
        check($sformatf("n%0d_done", N), 64'(done), 64'(rem == 1));
        if (done && q.size() > 0) begin
          got = q.pop_front();
          check($sformatf("n%0d_result", N), 64'(result), 64'(got.sum));
          check($sformatf("n%0d_latency", N), 64'(cyc - got.first + 1), 64'(got.lat));
        end
      end
    end
  end

  task automatic kick(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk); #1;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_pair(input string tag, input logic [7:0] exp);
    check(tag, 64'({g_dut[0].add_a, g_dut[0].add_b}), 64'(exp));
  endtask

  logic [7:0] pairs1 [4];
  logic [7:0] pairs2 [7];
  int         guard;

  initial begin
    pairs1 = '{8'h11, 8'h00, 8'h00, 8'h00};
    pairs2 = '{8'hF1, 8'hF0, 8'hF1, 8'hF0, 8'hF1, 8'hF0, 8'hF1};

    #1;
    check("rst_busy",   64'(g_dut[0].busy),   64'd0);
    check("rst_done",   64'(g_dut[0].done),   64'd0);
    check("rst_result", 64'(g_dut[0].result), 64'd0);
    check("rst_add",    64'({g_dut[0].add_a, g_dut[0].add_b}), 64'd0);
    check("rst_result_n1", 64'(g_dut[1].result), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    kick(16'h0001, 16'h0001);
    check_pair("add_pair_t1", pairs1[0]);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_pair("add_pair_t1", pairs1[i]);
    end
    repeat (3) @(negedge clk);
    check("t1_result", 64'(g_dut[0].result), 64'h00002);

    kick(16'hFFFF, 16'h0001);
    check_pair("add_pair_t2", pairs2[0]);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check_pair("add_pair_t2", pairs2[i]);
    end
    repeat (3) @(negedge clk);
    check("t2_result", 64'(g_dut[0].result), 64'h10000);

    kick(16'hFFFF, 16'hFFFF);
    repeat (10) @(negedge clk);
    check("t3_result", 64'(g_dut[0].result), 64'h1FFFE);

    @(negedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    kick(16'hFFFF, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    check("fix_add_b", 64'(g_dut[0].add_b), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   64'(g_dut[0].busy),   64'd0);
    check("mid_rst_done",   64'(g_dut[0].done),   64'd0);
    check("mid_rst_result", 64'(g_dut[0].result), 64'd0);
    check("mid_rst_add",    64'({g_dut[0].add_a, g_dut[0].add_b}), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    kick(16'h1234, 16'h4321);
    repeat (8) @(negedge clk);
    check("post_rst_result", 64'(g_dut[0].result), 64'h05555);

    guard = 0;
    while (g_dut[0].accepts < 2100 && guard < 40000) begin
      @(negedge clk); #1;
      op_a  = ($urandom_range(0, 3) == 0) ? (16'hFFFF ^ (16'd1 << $urandom_range(0, 15))) : 16'($urandom);
      op_b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      start = ($urandom_range(0, 3) != 0);
      guard++;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("n4_accepts_reached", 64'(g_dut[0].accepts >= 2100), 64'd1);
    check("n4_queue_drained", 64'(g_dut[0].q.size()), 64'd0);
    check("n1_queue_drained", 64'(g_dut[1].q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
